sync_fifo: RTL and testbench

//  Single-clock parametrised FIFO for buffering within one clock domain (CPU-side request/response queues).

---
 rtl/sync_fifo.sv | 148 ++++++++++++++
 tb/tb_sync_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO: any depth >= 2, optional first-word-fall-through,
// fill level, almost-full/almost-empty thresholds, flush and error pulses.
module sync_fifo #(
   parameter int WIDTH         = 34,
   parameter int DEPTH         = 8,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = DEPTH - 1,
   parameter int AEMPTY_THRESH = 1,
   parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 w_en,
   output logic                 full,
   output logic                 almost_full,
   output logic [WIDTH-1:0]     data_out,
   input  logic                 r_en,
   output logic                 empty,
   output logic                 almost_empty,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(AFULL_THRESH);
   localparam logic [CNT_WIDTH-1:0] CNT_AE   = CNT_WIDTH'(AEMPTY_THRESH);

   if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be >= 2");
   end
   if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo: AFULL_THRESH must be in 1..DEPTH");
   end
   if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo: AEMPTY_THRESH must be in 0..DEPTH-1");
   end

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0]     wptr_q, wptr_d;
   logic [PTR_W-1:0]     rptr_q, rptr_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 ovf_q, ovf_d;
   logic                 udf_q, udf_d;

   logic full_w;
   logic empty_w;
   logic wr_ok;
   logic rd_ok;

   // Binary pointers wrap explicitly so DEPTH need not be a power of two
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_w  = (count_q == CNT_FULL);
   assign empty_w = (count_q == '0);

   assign wr_ok = w_en && !full_w && !flush;
   assign rd_ok = r_en && !empty_w && !flush;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         ovf_d = w_en && full_w;
         udf_d = r_en && empty_w;
         if (wr_ok) begin
            wptr_d = ptr_inc(wptr_q);
         end
         if (rd_ok) begin
            rptr_d = ptr_inc(rptr_q);
         end
         if (wr_ok && !rd_ok) begin
            count_d = count_q + CNT_WIDTH'(1);
         end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_ok && !rst) begin
         mem_q[wptr_q] <= data_in;
      end
   end

   if (FWFT == 0) begin : g_reg_rd
      logic [WIDTH-1:0] dout_q, dout_d;

      always_comb begin
         dout_d = dout_q;
         if (rd_ok) begin
            dout_d = mem_q[rptr_q];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            dout_q <= '0;
         end else begin
            dout_q <= dout_d;
         end
      end

      assign data_out = dout_q;
   end else begin : g_fwft_rd
      assign data_out = empty_w ? '0 : mem_q[rptr_q];
   end

   assign count        = count_q;
   assign full         = full_w;
   assign empty        = empty_w;
   assign almost_full  = (count_q >= CNT_AF);
   assign almost_empty = (count_q <= CNT_AE);
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: registered-read and FWFT instances driven in
// lockstep, checked against a queue model of the FIFO.
module tb_sync_fifo;

   localparam int W  = 34;
   localparam int D  = 5;
   localparam int AF = 4;
   localparam int AE = 1;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          w_en = 1'b0;
   logic          r_en = 1'b0;
   logic [W-1:0]  data_in = '0;

   logic [W-1:0]  dout0, dout1;
   logic [CW-1:0] cnt0, cnt1;
   logic          full0, full1, af0, af1;
   logic          empty0, empty1, ae0, ae1;
   logic          ovf0, ovf1, udf0, udf1;

   int n_chk = 0;
   int n_bad = 0;

   logic [W-1:0] q[$];
   logic [W-1:0] m_dreg;
   logic         m_ovf, m_udf;

   always #5 clk = ~clk;

   sync_fifo #(
      .WIDTH(W), .DEPTH(D), .FWFT(0),
      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
   ) u_reg (
      .clk(clk), .rst(rst), .flush(flush),
      .data_in(data_in), .w_en(w_en),
      .full(full0), .almost_full(af0),
      .data_out(dout0), .r_en(r_en),
      .empty(empty0), .almost_empty(ae0),
      .count(cnt0), .overflow(ovf0), .underflow(udf0)
   );

   sync_fifo #(
      .WIDTH(W), .DEPTH(D), .FWFT(1),
      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
   ) u_fwft (
      .clk(clk), .rst(rst), .flush(flush),
      .data_in(data_in), .w_en(w_en),
      .full(full1), .almost_full(af1),
      .data_out(dout1), .r_en(r_en),
      .empty(empty1), .almost_empty(ae1),
      .count(cnt1), .overflow(ovf1), .underflow(udf1)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h",
                  tag, $time, got, exp);
      end
   endtask

   task automatic check_all();
      int n;
      logic [W-1:0] head;
      n = q.size();
      head = (n != 0) ? q[0] : '0;
      chk("cnt0",   64'(cnt0),   64'(n));
      chk("cnt1",   64'(cnt1),   64'(n));
      chk("full0",  64'(full0),  64'(n == D));
      chk("full1",  64'(full1),  64'(n == D));
      chk("empty0", 64'(empty0), 64'(n == 0));
      chk("empty1", 64'(empty1), 64'(n == 0));
      chk("af0",    64'(af0),    64'(n >= AF));
      chk("af1",    64'(af1),    64'(n >= AF));
      chk("ae0",    64'(ae0),    64'(n <= AE));
      chk("ae1",    64'(ae1),    64'(n <= AE));
      chk("ovf0",   64'(ovf0),   64'(m_ovf));
      chk("ovf1",   64'(ovf1),   64'(m_ovf));
      chk("udf0",   64'(udf0),   64'(m_udf));
      chk("udf1",   64'(udf1),   64'(m_udf));
      chk("dreg",   64'(dout0),  64'(m_dreg));
      chk("dfwft",  64'(dout1),  64'(head));
   endtask

   // One clock: drive, update the model from pre-edge occupancy, then check
   task automatic step(input bit rs, input bit fl,
                       input bit w, input bit r,
                       input logic [W-1:0] d);
      int n;
      rst = rs;
      flush = fl;
      w_en = w;
      r_en = r;
      data_in = d;
      @(posedge clk);
      n = q.size();
      if (rs) begin
         q.delete();
         m_dreg = '0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else if (fl) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         m_ovf = w && (n == D);
         m_udf = r && (n == 0);
         if (r && n != 0) m_dreg = q.pop_front();
         if (w && n != D) q.push_back(d);
      end
      #1;
      check_all();
   endtask

   initial begin
      int wp;
      bit w, r, fl, rs;
      m_dreg = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;

      step(1, 0, 1, 1, W'(34'h3_dead_beef));

      for (int i = 1; i <= 6; i++) step(0, 0, 1, 0, W'(i));
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, '0);

      for (int i = 0; i < 12; i++) begin
         step(0, 0, 1, (i >= 2), W'(32'h10 + i));
      end
      step(0, 0, 0, 1, '0);
      step(0, 0, 0, 1, '0);

      for (int i = 0; i < 5; i++) step(0, 0, 1, 0, W'(32'h20 + i));
      step(0, 0, 1, 1, W'(32'h77));
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, '0);
      step(0, 0, 1, 1, W'(32'h55));
      step(0, 0, 0, 1, '0);

      step(1, 0, 0, 0, '0);
      step(0, 0, 1, 0, W'(32'hA));
      step(0, 0, 0, 1, '0);

      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, W'(32'h30 + i));
      step(0, 0, 0, 1, '0);
      step(0, 0, 1, 0, W'(32'h40));
      step(0, 1, 1, 1, W'(32'h41));
      step(0, 0, 1, 0, W'(32'h42));
      step(0, 0, 1, 0, W'(32'h43));
      step(1, 0, 1, 1, W'(32'h44));

      wp = 50;
      for (int i = 0; i < 800; i++) begin
         if (i % 40 == 0) wp = $urandom_range(10, 90);
         w  = ($urandom_range(0, 99) < wp);
         r  = ($urandom_range(0, 99) >= wp);
         fl = ($urandom_range(0, 99) < 2);
         rs = ($urandom_range(0, 99) < 1);
         step(rs, fl, w, r, {$urandom(), 2'($urandom())});
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
